// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the seg_display_arbiter codebase slice.
// Holds the BCD word width, the arbiter state encoding and the round-robin
// search function used by rr_pick_logic.
package seg_disp_pkg;

    localparam int BCD_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_result_t;

    // Round-robin search over up to four requesters: first set bit strictly
    // after 'last', wrapping modulo n, with 'last' itself examined last.
    function automatic rr_result_t rr_pick(input logic [3:0] req,
                                           input logic [1:0] last,
                                           input int unsigned n);
        rr_result_t  r;
        int unsigned c;
        r.found = 1'b0;
        r.idx   = 2'd0;
        for (int unsigned off = 1; off <= 4; off++) begin
            c = ({30'd0, last} + off) % n;
            if ((off <= n) && !r.found && req[c[1:0]]) begin
                r.found = 1'b1;
                r.idx   = c[1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin priority search for seg_display_arbiter.
// Pads the request vector to four bits and applies seg_disp_pkg::rr_pick.
module rr_pick_logic
    import seg_disp_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_last,
    output logic [1:0]      o_idx,
    output logic            o_found
);

    logic [3:0] w_req_pad;
    rr_result_t w_res;

    // Zero-extend the request vector and run the wrap-around search.
    always_comb begin
        w_req_pad             = 4'b0000;
        w_req_pad[NREQ-1:0]   = i_req;
        w_res                 = rr_pick(w_req_pad, i_last, NREQ);
    end

    assign o_idx   = w_res.idx;
    assign o_found = w_res.found;

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares one 4-digit 7-segment display between NREQ
// requesters with registered one-hot round-robin grants and a minimum hold.
// Optional feature macro: ARB_PREEMPT_EN -- when defined, a contended owner
// still requesting is rotated out after MAX_HOLD cycles.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int          NREQ       = 3,
    parameter int          MIN_HOLD   = 50_000_000,
    parameter int          MAX_HOLD   = 200_000_000,
    parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
    input  logic                  clk_100mhz,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [BCD_W*NREQ-1:0] bcd_in,
    output logic [NREQ-1:0]       grant,
    output logic [1:0]            owner_id,
    output logic                  busy,
    output logic [BCD_W-1:0]      bcd_out
);

    localparam int                CNT_W     = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0]  HELD_AT   = CNT_W'(MIN_HOLD - 1);
`ifdef ARB_PREEMPT_EN
    localparam logic [CNT_W-1:0]  MAX_AT    = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = MAX_AT;
`else
    localparam logic [CNT_W-1:0]  CNT_SAT   = HELD_AT;
`endif
    localparam logic [NREQ-1:0]   GRANT_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [BCD_W-1:0] w_words [NREQ];
    logic [1:0]       w_idx;
    logic             w_found;
    logic             w_held;
    logic             w_own_req;
    logic             w_others;
    logic             w_preempt;
    logic             w_load;
    logic             w_release;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_words
            assign w_words[gi] = bcd_in[BCD_W*gi +: BCD_W];
        end
    endgenerate

    rr_pick_logic #(.NREQ(NREQ)) u_pick (
        .i_req   (req),
        .i_last  (owner_id),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    assign w_held    = (r_cnt >= HELD_AT);
    assign w_own_req = req[owner_id];
    assign w_others  = |(req & ~grant);
`ifdef ARB_PREEMPT_EN
    assign w_preempt = (r_cnt >= MAX_AT) && w_own_req && w_others;
`else
    assign w_preempt = 1'b0;
`endif

    // Decide whether this edge loads a new owner or releases to idle.
    always_comb begin
        w_load    = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = w_found;
            end
            OWNED: begin
                if (w_held && !w_own_req) begin
                    w_load    = w_found;
                    w_release = !w_found;
                end else begin
                    w_load    = w_preempt;
                end
            end
            default: begin
                w_release = 1'b1;
            end
        endcase
    end

    // Arbiter FSM with hold counter and registered display outputs.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            grant    <= '0;
            owner_id <= 2'(NREQ - 1);
            busy     <= 1'b0;
            bcd_out  <= IDLE_VALUE;
        end else if (w_load) begin
            r_state  <= OWNED;
            r_cnt    <= '0;
            grant    <= GRANT_ONE << w_idx;
            owner_id <= w_idx;
            busy     <= 1'b1;
            bcd_out  <= w_words[w_idx];
        end else if (w_release) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            bcd_out  <= IDLE_VALUE;
        end else if (r_state == OWNED) begin
            if (r_cnt < CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_own_req) begin
                bcd_out <= w_words[owner_id];
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed self-checking bench for seg_display_arbiter (NREQ=3, MIN_HOLD=4,
// MAX_HOLD=10). Expected outputs are queued as stimulus is applied and
// popped for comparison after each clock edge. Honours ARB_PREEMPT_EN.
module tb_seg_display_arbiter;

    localparam int NREQ = 3;

    typedef struct packed {
        logic [2:0]  g;
        logic        b;
        logic [1:0]  o;
        logic [15:0] d;
    } exp_t;

    logic        clk_100mhz = 1'b0;
    logic        rst        = 1'b0;
    logic [2:0]  req        = 3'b000;
    logic [47:0] bcd_in     = 48'h0;
    logic [2:0]  grant;
    logic [1:0]  owner_id;
    logic        busy;
    logic [15:0] bcd_out;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] words [3];

    seg_display_arbiter #(
        .NREQ       (NREQ),
        .MIN_HOLD   (4),
        .MAX_HOLD   (10),
        .IDLE_VALUE (16'h0000)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .req        (req),
        .bcd_in     (bcd_in),
        .grant      (grant),
        .owner_id   (owner_id),
        .busy       (busy),
        .bcd_out    (bcd_out)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic push(input logic [2:0] g, input logic b, input logic [1:0] o, input logic [15:0] d);
        q.push_back({g, b, o, d});
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        exp_t a;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            a = {grant, busy, owner_id, bcd_out};
            assert (a === e) else begin
                errors++;
                $error("FAIL %s: got grant=%b busy=%b owner=%0d bcd=%h, expected grant=%b busy=%b owner=%0d bcd=%h",
                       tag, a.g, a.b, a.o, a.d, e.g, e.b, e.o, e.d);
            end
        end
    endtask

    task automatic tick_check(input string tag);
        @(posedge clk_100mhz);
        #1;
        check_now(tag);
    endtask

    task automatic hold_ticks(input int n, input string tag, input logic [2:0] g,
                              input logic b, input logic [1:0] o, input logic [15:0] d);
        for (int i = 0; i < n; i++) begin
            push(g, b, o, d);
            tick_check(tag);
        end
    endtask

    task automatic set_word(input int i, input logic [15:0] v);
        bcd_in[16*i +: 16] = v;
    endtask

    task automatic reset_pulse();
        req = 3'b000;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // Power-on reset state.
        #1 rst = 1'b1;
        #2;
        push(3'b000, 1'b0, 2'd2, 16'h0000);
        check_now("reset_state");
        #9 rst = 1'b0;

        // Single request, then tracking, then drop -> frozen value, then idle.
        set_word(0, 16'h1234);
        req = 3'b001;
        push(3'b001, 1'b1, 2'd0, 16'h1234);
        tick_check("single_grant");
        set_word(0, 16'h5678);
        push(3'b001, 1'b1, 2'd0, 16'h5678);
        tick_check("single_track");
        req = 3'b000;
        set_word(0, 16'hDEAD);
        hold_ticks(2, "single_frozen", 3'b001, 1'b1, 2'd0, 16'h5678);
        push(3'b000, 1'b0, 2'd0, 16'h0000);
        tick_check("single_release");

        // Asynchronous reset mid-grant, observed before the next clock.
        set_word(0, 16'h1234);
        req = 3'b001;
        push(3'b001, 1'b1, 2'd0, 16'h1234);
        tick_check("pre_reset_grant");
        #2 rst = 1'b1;
        #1;
        push(3'b000, 1'b0, 2'd2, 16'h0000);
        check_now("async_reset");
        req = 3'b000;
        rst = 1'b0;

        // Early drop: one-cycle request still holds for four cycles.
        req = 3'b001;
        push(3'b001, 1'b1, 2'd0, 16'h1234);
        tick_check("early_grant");
        req = 3'b000;
        set_word(0, 16'h9999);
        hold_ticks(3, "early_hold", 3'b001, 1'b1, 2'd0, 16'h1234);
        push(3'b000, 1'b0, 2'd0, 16'h0000);
        tick_check("early_release");

        // Round-robin with all three requesting, no idle gap between owners.
        reset_pulse();
        words[0] = 16'hA000;
        words[1] = 16'hB111;
        words[2] = 16'hC222;
        for (int i = 0; i < 3; i++) set_word(i, words[i]);
        req = 3'b111;
        push(3'b001, 1'b1, 2'd0, words[0]);
        tick_check("rr_first");
        for (int s = 0; s < 3; s++) begin
            int nk;
            nk  = (s + 1) % 3;
            req = 3'b111 & ~(3'b001 << s);
            hold_ticks(3, "rr_hold", 3'b001 << s, 1'b1, 2'(s), words[s]);
            push(3'b001 << nk, 1'b1, 2'(nk), words[nk]);
            tick_check("rr_switch");
        end

        // Contention 101 from reset; requester 1 toggles its word throughout.
        reset_pulse();
        set_word(0, 16'h1111);
        set_word(2, 16'h2222);
        req = 3'b101;
        push(3'b001, 1'b1, 2'd0, 16'h1111);
        tick_check("cont_first");
        req = 3'b100;
        for (int i = 0; i < 3; i++) begin
            set_word(1, 16'($urandom));
            push(3'b001, 1'b1, 2'd0, 16'h1111);
            tick_check("cont_hold");
        end
        set_word(1, 16'($urandom));
        push(3'b100, 1'b1, 2'd2, 16'h2222);
        tick_check("cont_switch");
        for (int i = 0; i < 4; i++) begin
            set_word(1, 16'($urandom));
            push(3'b100, 1'b1, 2'd2, 16'h2222);
            tick_check("cont_owner2");
        end
        req = 3'b000;
        set_word(1, 16'($urandom));
        push(3'b000, 1'b0, 2'd2, 16'h0000);
        tick_check("cont_idle");

        // Continuous 011 request: preemption rotation, or a sticky owner.
        reset_pulse();
        set_word(0, 16'h0A0A);
        set_word(1, 16'h0B0B);
        req = 3'b011;
        push(3'b001, 1'b1, 2'd0, 16'h0A0A);
        tick_check("pre_first");
`ifdef ARB_PREEMPT_EN
        hold_ticks(9, "pre_hold0", 3'b001, 1'b1, 2'd0, 16'h0A0A);
        push(3'b010, 1'b1, 2'd1, 16'h0B0B);
        tick_check("pre_rotate1");
        hold_ticks(9, "pre_hold1", 3'b010, 1'b1, 2'd1, 16'h0B0B);
        push(3'b001, 1'b1, 2'd0, 16'h0A0A);
        tick_check("pre_rotate0");
`else
        hold_ticks(25, "sticky_owner", 3'b001, 1'b1, 2'd0, 16'h0A0A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 4-digit 7-segment display between NREQ independent requesters, such as a counter, a stopwatch and a status code.
- Grants are round-robin, one-hot and registered. Each grant enforces a minimum on-screen hold time so the display never flickers between sources.
- The registered 16-bit BCD/hex word bcd_out feeds the display driver's BCD input directly.

Parameters:
- NREQ, 3, number of requesters; legal range 2..4.
- MIN_HOLD, 50_000_000, minimum cycles a grant is held (0.5 s at 100 MHz); legal range >= 1.
- MAX_HOLD, 200_000_000, cycles after which a contended owner is preempted (used only with ARB_PREEMPT_EN); must satisfy MAX_HOLD >= MIN_HOLD.
- IDLE_VALUE, 16'h0000, bcd_out value while no requester owns the display.

Ports:
- clk_100mhz  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; a requester holds its bit high while it wants the display.
- bcd_in  input  16*NREQ  requester i's word on bits [16*i+15:16*i].
- grant  output  NREQ  one-hot grant, or all zero when idle; registered.
- owner_id  output  2  index of the current or last owner; registered.
- busy  output  1  high while any grant is active; registered.
- bcd_out  output  16  word to the display driver; registered.

Behaviour:
Reset (asynchronous, effective immediately, including mid-grant):
- grant=0, busy=0, owner_id=NREQ-1, so the first search starts at index 0.
- bcd_out=IDLE_VALUE, hold counter=0, state=IDLE.

State IDLE:
- If req != 0, pick the first set req bit searching from owner_id+1 upward with wrap modulo NREQ.
- On that same edge: grant[k]=1, owner_id=k, busy=1, bcd_out=bcd_in[k], hold counter=0; go to OWNED.
- Latency from req sampled high to grant and bcd_out valid is 1 cycle.

State OWNED:
- The hold counter increments every cycle and saturates; its width is clog2(MAX_HOLD)+1.
- held = (counter >= MIN_HOLD-1).
- While req[owner] is high, bcd_out tracks bcd_in[owner] each cycle with 1-cycle latency.
- If req[owner] falls before held, the grant is kept and bcd_out freezes at the last value sampled while req was high.
- On the edge where held is true and req[owner] is low:
  - If other requests are pending, do a round-robin pick from owner_id+1 and switch directly to the new owner, with no idle gap. The new grant and bcd_out load on the same edge and the counter clears; stay in OWNED.
  - If no requests are pending, go to IDLE: grant=0, busy=0, bcd_out=IDLE_VALUE; owner_id is retained.

Simultaneous events:
- Several req bits rising in the same cycle in IDLE: round-robin order decides the winner.
- req[owner] falling on the same edge held becomes true: release occurs on that edge.
- req[owner] re-rising after a drop but before release: treated as continued ownership; tracking resumes.

Invariants:
- grant is always one-hot or zero.
- A requester never regains the grant while another requester has been waiting continuously since the last arbitration point.
- Changes to bcd_in of non-owners have no effect on any output.

Optional Feature:
Macro ARB_PREEMPT_EN.
- Defined: in OWNED, if counter >= MAX_HOLD-1, req[owner] is still high, and some other req bit is high, the block rotates on that edge. The rotation uses the same pick rule and same-edge load as a normal switch. The preempted requester re-enters arbitration normally.
- Undefined: an owner keeps the display for as long as req stays high. MAX_HOLD is ignored and the counter saturates at MIN_HOLD-1.

Decomposition:
- Shared package seg_disp_pkg holds:
  - the BCD_W=16 localparam;
  - the state enum IDLE/OWNED;
  - the function rr_pick(req, last), which returns the next index and a found flag.
- One natural sub-module: rr_pick_logic, a combinational round-robin priority search. FSM, counter and output registers stay in the top.

Test Plan:
All scenarios use MIN_HOLD=4, MAX_HOLD=10, NREQ=3.
1. Reset: assert rst mid-grant -> grant=000, busy=0, bcd_out=16'h0000 immediately (asynchronously), before the next clock.
2. Single request: req=001, bcd_in[0]=16'h1234 -> one cycle later grant=001, bcd_out=16'h1234. Change bcd_in[0] to 16'h5678 -> bcd_out=16'h5678 the next cycle.
3. Early drop: req[0] high for 1 cycle only -> grant=001 held for 4 cycles with bcd_out frozen at 16'h1234, then grant=000 and bcd_out=16'h0000.
4. Round-robin: req=111 held, each owner dropping its req after hold -> grant sequence 001, 010, 100, 001, with no idle cycle between owners.
5. Contention: req=101 raised together from reset -> grant=001 first. After release, grant=100. Requester 1's bcd_in toggling throughout never affects bcd_out.
6. ARB_PREEMPT_EN defined, req=011 held continuously -> grant=001 for 10 cycles, then 010 for 10 cycles, alternating. With the macro undefined -> grant stays at 001 indefinitely.
